adc_mon_sched: RTL

ADC_MON_SCHED -- requirements
Module: adc_mon_sched

---
 rtl/adc_mon_pkg.sv | 30 +++
 rtl/adc_mon_rr.sv | 30 +++
 rtl/adc_mon_sched.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/adc_mon_pkg.sv
// Shared definitions for the ADC monitor scheduler: channel/mux encodings,
// FSM state encoding, timing defaults and the round-robin successor helper.
package adc_mon_pkg;

    localparam int SETTLE_CYC_DEF  = 4;
    localparam int TIMEOUT_CYC_DEF = 64;

    // Channel encodings double as the ADC mux select values
    typedef enum logic [1:0] {
        CH_V = 2'd0,
        CH_I = 2'd1,
        CH_T = 2'd2
    } ch_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CONV   = 2'd2,
        STORE  = 2'd3
    } state_e;

    function automatic ch_e ch_succ(input ch_e c);
        case (c)
            CH_V:    return CH_I;
            CH_I:    return CH_T;
            default: return CH_V;
        endcase
    endfunction

endpackage

// File: rtl/adc_mon_rr.sv
// Combinational round-robin picker: first enabled channel after the last
// served one, walking V->I->T->V.
module adc_mon_rr
    import adc_mon_pkg::*;
(
    input  logic [2:0] mon_en,
    input  ch_e        last,
    output ch_e        next_ch,
    output logic       any
);

    ch_e  cand;
    logic found;

    always_comb begin
        next_ch = last;
        found   = 1'b0;
        cand    = last;
        for (int k = 0; k < 3; k++) begin
            cand = ch_succ(cand);
            if (!found && mon_en[cand]) begin
                next_ch = cand;
                found   = 1'b1;
            end
        end
    end

    assign any = |mon_en;

endmodule

// File: rtl/adc_mon_sched.sv
// Shared-ADC scheduler for battery V/I/T monitoring (settle, convert, store).
// Optional macro MON_AVG_EN: store a rounded two-sample average instead of raw data.
module adc_mon_sched
    import adc_mon_pkg::*;
#(
    parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       vmonen,
    input  logic       imonen,
    input  logic       tmonen,
    input  logic       adc_done,
    input  logic [7:0] adc_data,
    output logic [1:0] adc_sel,
    output logic       adc_start,
    output logic [7:0] vbat,
    output logic [7:0] ibat,
    output logic [7:0] tbat,
    output logic       vtok,
    output logic       adc_err
);

    localparam logic [9:0] SETTLE_LAST  = 10'(SETTLE_CYC - 1);
    localparam logic [9:0] TIMEOUT_LAST = 10'(TIMEOUT_CYC - 1);

    state_e     state_reg, state_next;
    logic [9:0] cnt_reg, cnt_next;
    ch_e        sel_reg, sel_next;
    ch_e        last_reg, last_next;
    logic       start_reg, start_next;
    logic       err_reg, err_next;
    logic       keep_reg, keep_next;
    logic [2:0] valid_reg, valid_next;
    logic       vtok_reg;
    logic [2:0] mon_en;
    logic [2:0] cap;
    logic [7:0] data_reg [3];
    ch_e        rr_ch;
    logic       rr_any;

    assign mon_en = {tmonen, imonen, vmonen};

    adc_mon_rr u_rr (
        .mon_en  (mon_en),
        .last    (last_reg),
        .next_ch (rr_ch),
        .any     (rr_any)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        sel_next   = sel_reg;
        last_next  = last_reg;
        start_next = 1'b0;
        err_next   = err_reg;
        keep_next  = keep_reg;
        if (!en) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (rr_any) begin
                        sel_next   = rr_ch;
                        last_next  = rr_ch;
                        cnt_next   = '0;
                        state_next = SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt_reg == SETTLE_LAST) begin
                        cnt_next   = '0;
                        start_next = 1'b1;
                        state_next = CONV;
                    end else begin
                        cnt_next = cnt_reg + 10'd1;
                    end
                end
                CONV: begin
                    // A dropped channel enable still completes the cycle, minus the update
                    if (adc_done) begin
                        keep_next  = |cap;
                        state_next = STORE;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt_reg + 10'd1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_ch
            logic [7:0] cap_val;

            assign cap[gi] = (state_reg == CONV) && en && adc_done && mon_en[gi]
                             && (sel_reg == 2'(gi));

            assign valid_next[gi] = (!en || !mon_en[gi]) ? 1'b0 :
                                    ((state_reg == STORE) && keep_reg && (sel_reg == 2'(gi))) ? 1'b1 :
                                    valid_reg[gi];
`ifdef MON_AVG_EN
            logic [8:0] sum;
            assign sum     = {1'b0, data_reg[gi]} + {1'b0, adc_data} + 9'd1;
            assign cap_val = valid_reg[gi] ? sum[8:1] : adc_data;
`else
            assign cap_val = adc_data;
`endif
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_reg[gi] <= '0;
                end else if (cap[gi]) begin
                    data_reg[gi] <= cap_val;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            sel_reg   <= CH_V;
            last_reg  <= CH_T;
            start_reg <= 1'b0;
            err_reg   <= 1'b0;
            keep_reg  <= 1'b0;
            valid_reg <= '0;
            vtok_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            sel_reg   <= sel_next;
            last_reg  <= last_next;
            start_reg <= start_next;
            err_reg   <= err_next;
            keep_reg  <= keep_next;
            valid_reg <= valid_next;
            vtok_reg  <= valid_next[0] & valid_next[2];
        end
    end

    assign adc_sel   = sel_reg;
    assign adc_start = start_reg;
    assign vbat      = data_reg[0];
    assign ibat      = data_reg[1];
    assign tbat      = data_reg[2];
    assign vtok      = vtok_reg;
    assign adc_err   = err_reg;

endmodule
